// File: rtl/trace_pkg.sv
// Shared constants for the WB commit-trace buffer: entry layout,
// field offsets and parameter limits.
package trace_pkg;

    localparam int PC_W   = 32;
    localparam int RD_W   = 5;
    localparam int DATA_W = 32;
    localparam int DROP_W = 16;

    // Entry layout, LSB first: data, rd, pc, seq.
    // seq sits on top so its width can vary without moving the rest.
    localparam int OFF_DATA = 0;
    localparam int OFF_RD   = OFF_DATA + DATA_W;
    localparam int OFF_PC   = OFF_RD + RD_W;
    localparam int OFF_SEQ  = OFF_PC + PC_W;

    localparam int SEQ_W_DEF     = 16;
    localparam int TRACE_ENTRY_W = PC_W + RD_W + DATA_W + SEQ_W_DEF;

    localparam int DEPTH_MIN = 2;
    localparam int SEQ_W_MIN = 1;
    localparam int CNT_W_MIN = 1;

    function automatic int entry_w(int seq_w);
        return OFF_SEQ + seq_w;
    endfunction

endpackage

// File: rtl/wb_commit_trace_if.sv
// Trace output stream: head entry fields plus valid/ready handshake.
// master = trace buffer (drives valid/fields), slave = consumer (drives ready).
interface wb_commit_trace_if #(
    parameter int SEQ_W = 16
);
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [4:0]       out_rd;
    logic [31:0]      out_data;
    logic [SEQ_W-1:0] out_seq;

    modport master (
        output out_valid, out_pc, out_rd, out_data, out_seq,
        input  out_ready
    );

    modport slave (
        input  out_valid, out_pc, out_rd, out_data, out_seq,
        output out_ready
    );
endinterface

// File: rtl/trace_fifo.sv
// Generic synchronous first-word-fall-through FIFO on registered storage.
// Ports: push_i/din_i write, pop_i read, dout_o head, full_o/empty_o/level_o status.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 85,
    localparam int AW   = $clog2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  dout_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o
);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  last_q;
    logic [AW-1:0] wr_q;
    logic [AW-1:0] rd_q;
    logic [LW-1:0] cnt_q;
    logic          do_push;
    logic          do_pop;

    assign full_o  = (cnt_q == LW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign level_o = cnt_q;

    // A pop in the same cycle frees the slot, so a full FIFO still
    // accepts the push.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // When empty, keep presenting the last entry that left.
    assign dout_o = empty_o ? last_q : mem_q[rd_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + AW'(1);
            end
            if (do_pop) begin
                last_q <= mem_q[rd_q];
                rd_q   <= rd_q + AW'(1);
            end
            cnt_q <= cnt_q + LW'(do_push) - LW'(do_pop);
        end
    end

endmodule

// File: rtl/wb_commit_trace.sv
// Commit-trace buffer behind WB: tags register writes with a sequence
// number, queues them, and keeps retire/drop counters and an overflow flag.
// Ports: wb_* commit input, trace_freeze, clear_counters, tr (stream out),
// fifo_level, retired_count, drop_count, overflow_sticky.
module wb_commit_trace
    import trace_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter bit CAPTURE_X0 = 1'b0,
    parameter int SEQ_W      = 16,
    parameter int CNT_W      = 32,
    localparam int LW        = $clog2(DEPTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wb_enable,
    input  logic [4:0]           wb_rd,
    input  logic [31:0]          wb_data,
    input  logic [31:0]          wb_pc,
    input  logic                 trace_freeze,
    input  logic                 clear_counters,
    wb_commit_trace_if.master    tr,
    output logic [LW-1:0]        fifo_level,
    output logic [CNT_W-1:0]     retired_count,
    output logic [DROP_W-1:0]    drop_count,
    output logic                 overflow_sticky
);

    localparam int EW = entry_w(SEQ_W);

    if (DEPTH < DEPTH_MIN || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("DEPTH must be a power of two, at least 2");
    end

    logic [SEQ_W-1:0]  seq_q, seq_d;
    logic [CNT_W-1:0]  ret_q, ret_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              stk_q, stk_d;

    logic          ev;
    logic          push;
    logic          pop_fire;
    logic          drop;
    logic          full;
    logic          empty;
    logic [EW-1:0] din;
    logic [EW-1:0] head;

    assign ev       = wb_enable && (wb_rd != 5'd0 || CAPTURE_X0);
    assign push     = ev && !trace_freeze;
    assign pop_fire = !empty && tr.out_ready;
    assign drop     = push && full && !pop_fire;

    assign din = {seq_q, wb_pc, wb_rd, wb_data};

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (din),
        .pop_i   (tr.out_ready),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .level_o (fifo_level)
    );

    assign tr.out_valid = !empty;
    assign tr.out_data  = head[OFF_DATA +: DATA_W];
    assign tr.out_rd    = head[OFF_RD +: RD_W];
    assign tr.out_pc    = head[OFF_PC +: PC_W];
    assign tr.out_seq   = head[OFF_SEQ +: SEQ_W];

    always_comb begin
        seq_d  = seq_q + SEQ_W'(ev);
        // Clear first, then the event still counts.
        ret_d  = (clear_counters ? '0 : ret_q) + CNT_W'(ev);
        drop_d = drop_q;
        stk_d  = stk_q;
        if (clear_counters) begin
            drop_d = '0;
            stk_d  = 1'b0;
        end else if (drop) begin
            stk_d = 1'b1;
            if (drop_q != '1) drop_d = drop_q + DROP_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_q  <= '0;
            ret_q  <= '0;
            drop_q <= '0;
            stk_q  <= 1'b0;
        end else begin
            seq_q  <= seq_d;
            ret_q  <= ret_d;
            drop_q <= drop_d;
            stk_q  <= stk_d;
        end
    end

    assign retired_count   = ret_q;
    assign drop_count      = drop_q;
    assign overflow_sticky = stk_q;

endmodule

// File: tb/tb_wb_commit_trace.sv
// Directed bench for wb_commit_trace: two instances share stimulus,
// one ignoring x0 writes and one capturing them.
module tb_wb_commit_trace;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_enable = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic [31:0] wb_data = '0;
    logic [31:0] wb_pc = '0;
    logic        frz = 1'b0;
    logic        clr = 1'b0;
    logic        rdy = 1'b0;

    logic [3:0]  lvl0, lvl1;
    logic [31:0] ret0, ret1;
    logic [15:0] drp0, drp1;
    logic        stk0, stk1;

    int n_chk = 0;
    int n_pass = 0;

    wb_commit_trace_if #(.SEQ_W(16)) if0 ();
    wb_commit_trace_if #(.SEQ_W(16)) if1 ();

    assign if0.out_ready = rdy;
    assign if1.out_ready = rdy;

    always #5 clk = ~clk;

    wb_commit_trace #(
        .DEPTH(8), .CAPTURE_X0(1'b0), .SEQ_W(16), .CNT_W(32)
    ) d0 (
        .clk(clk), .rst(rst),
        .wb_enable(wb_enable), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc),
        .trace_freeze(frz), .clear_counters(clr),
        .tr(if0),
        .fifo_level(lvl0), .retired_count(ret0),
        .drop_count(drp0), .overflow_sticky(stk0)
    );

    wb_commit_trace #(
        .DEPTH(8), .CAPTURE_X0(1'b1), .SEQ_W(16), .CNT_W(32)
    ) d1 (
        .clk(clk), .rst(rst),
        .wb_enable(wb_enable), .wb_rd(wb_rd),
        .wb_data(wb_data), .wb_pc(wb_pc),
        .trace_freeze(frz), .clear_counters(clr),
        .tr(if1),
        .fifo_level(lvl1), .retired_count(ret1),
        .drop_count(drp1), .overflow_sticky(stk1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d,
                      input logic [31:0] pc);
        wb_enable = 1'b1;
        wb_rd     = rd;
        wb_data   = d;
        wb_pc     = pc;
        step();
        wb_enable = 1'b0;
    endtask

    task automatic do_reset();
        wb_enable = 1'b0;
        frz = 1'b0;
        clr = 1'b0;
        rdy = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_chk++; if (if0.out_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", if0.out_valid); else n_pass++;
        n_chk++; if (lvl0 !== 4'd0) $display("FAIL rst_level: got %0d want 0", lvl0); else n_pass++;
        n_chk++; if (ret0 !== 32'd0) $display("FAIL rst_retired: got %0d want 0", ret0); else n_pass++;
        n_chk++; if (drp0 !== 16'd0) $display("FAIL rst_drop: got %0d want 0", drp0); else n_pass++;
        n_chk++; if (stk0 !== 1'b0) $display("FAIL rst_sticky: got %0h want 0", stk0); else n_pass++;
        n_chk++; if (if0.out_seq !== 16'd0 || if0.out_pc !== 32'd0 || if0.out_data !== 32'd0 || if0.out_rd !== 5'd0)
            $display("FAIL rst_fields: got seq %0h pc %0h data %0h rd %0h want all 0",
                     if0.out_seq, if0.out_pc, if0.out_data, if0.out_rd);
        else n_pass++;
    endtask

    task automatic test_basic();
        rdy = 1'b1;
        wr(5'd1, 32'h5, 32'h0);
        n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'd0 || if0.out_rd !== 5'd1 || if0.out_data !== 32'h5 || if0.out_pc !== 32'h0)
            $display("FAIL basic_e0: got v%0h seq %0h rd %0h data %0h pc %0h want v1 seq 0 rd 1 data 5 pc 0",
                     if0.out_valid, if0.out_seq, if0.out_rd, if0.out_data, if0.out_pc);
        else n_pass++;
        wr(5'd2, 32'hA, 32'h4);
        n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'd1 || if0.out_rd !== 5'd2 || if0.out_data !== 32'hA || if0.out_pc !== 32'h4)
            $display("FAIL basic_e1: got v%0h seq %0h rd %0h data %0h pc %0h want v1 seq 1 rd 2 data a pc 4",
                     if0.out_valid, if0.out_seq, if0.out_rd, if0.out_data, if0.out_pc);
        else n_pass++;
        wr(5'd3, 32'hF, 32'h8);
        n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'd2 || if0.out_rd !== 5'd3 || if0.out_data !== 32'hF || if0.out_pc !== 32'h8)
            $display("FAIL basic_e2: got v%0h seq %0h rd %0h data %0h pc %0h want v1 seq 2 rd 3 data f pc 8",
                     if0.out_valid, if0.out_seq, if0.out_rd, if0.out_data, if0.out_pc);
        else n_pass++;
        n_chk++; if (lvl0 !== 4'd1) $display("FAIL basic_level: got %0d want 1", lvl0); else n_pass++;
        step();
        n_chk++; if (if0.out_valid !== 1'b0 || lvl0 !== 4'd0) $display("FAIL basic_empty: got v%0h lvl %0d want v0 lvl 0", if0.out_valid, lvl0); else n_pass++;
        n_chk++; if (if0.out_seq !== 16'd2 || if0.out_data !== 32'hF) $display("FAIL basic_hold: got seq %0h data %0h want 2 f", if0.out_seq, if0.out_data); else n_pass++;
        n_chk++; if (ret0 !== 32'd3) $display("FAIL basic_retired: got %0d want 3", ret0); else n_pass++;
        n_chk++; if (drp0 !== 16'd0) $display("FAIL basic_drop: got %0d want 0", drp0); else n_pass++;
    endtask

    task automatic test_x0();
        rdy = 1'b1;
        wr(5'd0, 32'h77, 32'h100);
        n_chk++; if (if0.out_valid !== 1'b0 || ret0 !== 32'd3) $display("FAIL x0_ignored: got v%0h ret %0d want v0 ret 3", if0.out_valid, ret0); else n_pass++;
        n_chk++; if (if1.out_valid !== 1'b1 || if1.out_rd !== 5'd0 || if1.out_data !== 32'h77 || if1.out_seq !== 16'd3)
            $display("FAIL x0_captured: got v%0h rd %0h data %0h seq %0h want v1 rd 0 data 77 seq 3",
                     if1.out_valid, if1.out_rd, if1.out_data, if1.out_seq);
        else n_pass++;
        n_chk++; if (ret1 !== 32'd4) $display("FAIL x0_retired: got %0d want 4", ret1); else n_pass++;
        step();
        wr(5'd4, 32'h44, 32'h104);
        n_chk++; if (if0.out_seq !== 16'd3) $display("FAIL x0_seq_nogap: got %0d want 3", if0.out_seq); else n_pass++;
        step();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) wr(5'(i + 1), 32'h100 + 32'(i), 32'(4 * i));
        n_chk++; if (lvl0 !== 4'd8) $display("FAIL ovf_level: got %0d want 8", lvl0); else n_pass++;
        n_chk++; if (drp0 !== 16'd2) $display("FAIL ovf_drop: got %0d want 2", drp0); else n_pass++;
        n_chk++; if (stk0 !== 1'b1) $display("FAIL ovf_sticky: got %0h want 1", stk0); else n_pass++;
        n_chk++; if (ret0 !== 32'd10) $display("FAIL ovf_retired: got %0d want 10", ret0); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            rdy = 1'b0;
            step();
            n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'(i) || if0.out_data !== 32'h100 + 32'(i))
                $display("FAIL ovf_drain%0d: got v%0h seq %0d data %0h want v1 seq %0d data %0h",
                         i, if0.out_valid, if0.out_seq, if0.out_data, i, 32'h100 + 32'(i));
            else n_pass++;
            rdy = 1'b1;
            step();
        end
        rdy = 1'b0;
        n_chk++; if (if0.out_valid !== 1'b0 || lvl0 !== 4'd0) $display("FAIL ovf_empty: got v%0h lvl %0d want v0 lvl 0", if0.out_valid, lvl0); else n_pass++;
        wr(5'd5, 32'hBEEF, 32'h40);
        n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'd10 || if0.out_data !== 32'hBEEF)
            $display("FAIL ovf_next_seq: got v%0h seq %0d data %0h want v1 seq 10 data beef", if0.out_valid, if0.out_seq, if0.out_data);
        else n_pass++;
        n_chk++; if (stk0 !== 1'b1) $display("FAIL ovf_sticky_hold: got %0h want 1", stk0); else n_pass++;
        rdy = 1'b1;
        step();
    endtask

    task automatic test_full_pushpop();
        do_reset();
        for (int i = 0; i < 8; i++) wr(5'd6, 32'h200 + 32'(i), 32'h80 + 32'(4 * i));
        n_chk++; if (lvl0 !== 4'd8) $display("FAIL fpp_full: got %0d want 8", lvl0); else n_pass++;
        rdy = 1'b1;
        wr(5'd9, 32'h2FF, 32'hC0);
        n_chk++; if (lvl0 !== 4'd8) $display("FAIL fpp_level: got %0d want 8", lvl0); else n_pass++;
        n_chk++; if (drp0 !== 16'd0 || stk0 !== 1'b0) $display("FAIL fpp_drop: got %0d sticky %0h want 0 0", drp0, stk0); else n_pass++;
        for (int i = 1; i <= 8; i++) begin
            n_chk++; if (if0.out_seq !== 16'(i) || if0.out_data !== (i == 8 ? 32'h2FF : 32'h200 + 32'(i)))
                $display("FAIL fpp_order%0d: got seq %0d data %0h want seq %0d data %0h",
                         i, if0.out_seq, if0.out_data, i, (i == 8 ? 32'h2FF : 32'h200 + 32'(i)));
            else n_pass++;
            step();
        end
        n_chk++; if (if0.out_valid !== 1'b0) $display("FAIL fpp_empty: got %0h want 0", if0.out_valid); else n_pass++;
    endtask

    task automatic test_freeze();
        do_reset();
        rdy = 1'b1;
        wr(5'd1, 32'h11, 32'h0);
        n_chk++; if (if0.out_seq !== 16'd0 || if0.out_valid !== 1'b1) $display("FAIL frz_first: got v%0h seq %0d want v1 seq 0", if0.out_valid, if0.out_seq); else n_pass++;
        frz = 1'b1;
        for (int i = 0; i < 4; i++) wr(5'd2, 32'h30 + 32'(i), 32'h10 + 32'(i));
        n_chk++; if (ret0 !== 32'd5) $display("FAIL frz_retired: got %0d want 5", ret0); else n_pass++;
        n_chk++; if (if0.out_valid !== 1'b0 || lvl0 !== 4'd0) $display("FAIL frz_noentry: got v%0h lvl %0d want v0 lvl 0", if0.out_valid, lvl0); else n_pass++;
        n_chk++; if (drp0 !== 16'd0 || stk0 !== 1'b0) $display("FAIL frz_nodrop: got %0d sticky %0h want 0 0", drp0, stk0); else n_pass++;
        frz = 1'b0;
        wr(5'd2, 32'h22, 32'h20);
        n_chk++; if (if0.out_seq !== 16'd5 || if0.out_data !== 32'h22) $display("FAIL frz_seq_jump: got seq %0d data %0h want seq 5 data 22", if0.out_seq, if0.out_data); else n_pass++;
        step();
    endtask

    task automatic test_clear();
        do_reset();
        for (int i = 0; i < 9; i++) wr(5'd3, 32'h300 + 32'(i), 32'(i));
        n_chk++; if (drp0 !== 16'd1 || stk0 !== 1'b1 || ret0 !== 32'd9)
            $display("FAIL clr_pre: got drop %0d sticky %0h ret %0d want 1 1 9", drp0, stk0, ret0);
        else n_pass++;
        clr = 1'b1;
        wr(5'd3, 32'h3FF, 32'h99);
        clr = 1'b0;
        n_chk++; if (ret0 !== 32'd1) $display("FAIL clr_retired: got %0d want 1", ret0); else n_pass++;
        n_chk++; if (drp0 !== 16'd0 || stk0 !== 1'b0) $display("FAIL clr_drop: got %0d sticky %0h want 0 0", drp0, stk0); else n_pass++;
        n_chk++; if (lvl0 !== 4'd8 || if0.out_seq !== 16'd0) $display("FAIL clr_fifo: got lvl %0d seq %0d want 8 0", lvl0, if0.out_seq); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 5; i++) wr(5'd4, 32'h400 + 32'(i), 32'(i));
        n_chk++; if (lvl0 !== 4'd5) $display("FAIL rmid_level: got %0d want 5", lvl0); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_chk++; if (if0.out_valid !== 1'b0 || lvl0 !== 4'd0) $display("FAIL rmid_async: got v%0h lvl %0d want v0 lvl 0", if0.out_valid, lvl0); else n_pass++;
        n_chk++; if (ret0 !== 32'd0 || drp0 !== 16'd0) $display("FAIL rmid_counts: got ret %0d drop %0d want 0 0", ret0, drp0); else n_pass++;
        step();
        rst = 1'b0;
        wr(5'd7, 32'h77, 32'h70);
        n_chk++; if (if0.out_valid !== 1'b1 || if0.out_seq !== 16'd0 || if0.out_data !== 32'h77)
            $display("FAIL rmid_seq0: got v%0h seq %0d data %0h want v1 seq 0 data 77", if0.out_valid, if0.out_seq, if0.out_data);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_overflow();
        test_full_pushpop();
        test_freeze();
        test_clear();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
